// File: rtl/perceptron_activation.sv
// Accumulates BEATS signed 4-bit partial sums with saturation, thresholds the total
// into a ternary activation and offers the result over a valid/ready handshake.
module perceptron_activation #(
  parameter int BEATS  = 4,
  parameter int ACC_W  = 8,
  parameter int THRESH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [3:0]       sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [1:0]       act_out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  // Comparisons run one bit wider than the accumulator so the raw sum never wraps.
  localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] THR_POS = THRESH[ACC_W:0];
  localparam logic signed [ACC_W:0] THR_NEG = -THR_POS;
  localparam logic [7:0]            LAST_BEAT = 8'(BEATS - 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ACC_W-1:0]        acc_out_q, acc_out_d;
  logic [1:0]              act_q, act_d;

  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W:0]   sat_wide;
  logic [ACC_W-1:0]        acc_sat;
  logic [1:0]              act_sat;

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-3){sum_in[3]}}, sum_in};
    if (sum_wide > SAT_MAX) begin
      acc_sat = SAT_MAX[ACC_W-1:0];
    end else if (sum_wide < SAT_MIN) begin
      acc_sat = SAT_MIN[ACC_W-1:0];
    end else begin
      acc_sat = sum_wide[ACC_W-1:0];
    end
    sat_wide = {acc_sat[ACC_W-1], acc_sat};
    if (sat_wide > THR_POS) begin
      act_sat = ACT_POS;
    end else if (sat_wide < THR_NEG) begin
      act_sat = ACT_NEG;
    end else begin
      act_sat = ACT_ZERO;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_out_d = acc_out_q;
    act_d     = act_q;
    if (clear) begin
      state_d   = S_ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      acc_out_d = '0;
      act_d     = ACT_ZERO;
    end else if (state_q == S_ACCUM) begin
      if (in_valid) begin
        if (cnt_q == LAST_BEAT) begin
          // Result is captured here so it appears exactly one clock after the last beat.
          acc_out_d = acc_sat;
          act_d     = act_sat;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = S_DONE;
        end else begin
          acc_d = acc_sat;
          cnt_d = cnt_q + 8'd1;
        end
      end
    end else begin
      if (out_ready) begin
        state_d = S_ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_out_q <= '0;
      act_q     <= ACT_ZERO;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_out_q <= acc_out_d;
      act_q     <= act_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign acc_out   = acc_out_q;
  assign act_out   = act_q;

endmodule

// File: tb/tb_perceptron_activation.sv
// Bench for perceptron_activation: four instances (default, ACC_W=4, BEATS=1, BEATS=7)
// exercised by a vector table, hand-written corner sequences and a random run.
module tb_perceptron_activation;

  logic       clk;
  logic       rst_v  [4];
  logic       clr_v  [4];
  logic       iv_v   [4];
  logic       ordy_v [4];
  logic [3:0] sum_v  [4];
  logic       ir_v   [4];
  logic       ov_v   [4];
  logic [1:0] act_v  [4];
  logic [7:0] acc0, acc2, acc3;
  logic [3:0] acc1;

  int n_tests;
  int n_fail;

  int beats_of [4] = '{4, 4, 1, 7};
  int accw_of  [4] = '{8, 4, 8, 8};
  int thr_of   [4] = '{1, 1, 0, 5};

  // Reference model state: running sum, beat count, pending result, held result.
  int m_acc [4];
  int m_cnt [4];
  int m_res [4];
  bit m_pend [4];
  bit m_zero [4];

  perceptron_activation #(.BEATS(4), .ACC_W(8), .THRESH(1)) u_def (
    .clk(clk), .reset(rst_v[0]), .clear(clr_v[0]), .sum_in(sum_v[0]), .in_valid(iv_v[0]),
    .in_ready(ir_v[0]), .acc_out(acc0), .act_out(act_v[0]), .out_valid(ov_v[0]),
    .out_ready(ordy_v[0]));

  perceptron_activation #(.BEATS(4), .ACC_W(4), .THRESH(1)) u_w4 (
    .clk(clk), .reset(rst_v[1]), .clear(clr_v[1]), .sum_in(sum_v[1]), .in_valid(iv_v[1]),
    .in_ready(ir_v[1]), .acc_out(acc1), .act_out(act_v[1]), .out_valid(ov_v[1]),
    .out_ready(ordy_v[1]));

  perceptron_activation #(.BEATS(1), .ACC_W(8), .THRESH(0)) u_b1 (
    .clk(clk), .reset(rst_v[2]), .clear(clr_v[2]), .sum_in(sum_v[2]), .in_valid(iv_v[2]),
    .in_ready(ir_v[2]), .acc_out(acc2), .act_out(act_v[2]), .out_valid(ov_v[2]),
    .out_ready(ordy_v[2]));

  perceptron_activation #(.BEATS(7), .ACC_W(8), .THRESH(5)) u_b7 (
    .clk(clk), .reset(rst_v[3]), .clear(clr_v[3]), .sum_in(sum_v[3]), .in_valid(iv_v[3]),
    .in_ready(ir_v[3]), .acc_out(acc3), .act_out(act_v[3]), .out_valid(ov_v[3]),
    .out_ready(ordy_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    int         b0, b1, b2, b3;
    int         exp_acc;
    logic [1:0] exp_act;
  } vec_t;

  vec_t vecs [10];

  function automatic int acc_of(input int i);
    case (i)
      0: return int'($signed(acc0));
      1: return int'($signed(acc1));
      2: return int'($signed(acc2));
      default: return int'($signed(acc3));
    endcase
  endfunction

  function automatic int act_ref(input int v, input int th);
    if (v > th) return 1;
    if (v < -th) return 3;
    return 0;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int i, input int s);
    iv_v[i]   = 1'b1;
    sum_v[i]  = 4'(s);
    ordy_v[i] = 1'b0;
    clk1();
  endtask

  // Four back-to-back beats; result must appear exactly one clock after the fourth.
  task automatic beats4(input int i, input int a, input int b, input int c, input int d,
                        input int exp_acc, input int exp_act, input bit do_ack);
    int s [4];
    s = '{a, b, c, d};
    check("in_ready_before", int'(ir_v[i]), 1);
    for (int k = 0; k < 4; k++) begin
      beat(i, s[k]);
      if (k < 3) check("early_valid", int'(ov_v[i]), 0);
    end
    iv_v[i] = 1'b0;
    check("out_valid", int'(ov_v[i]), 1);
    check("acc_out", acc_of(i), exp_acc);
    check("act_out", int'(act_v[i]), exp_act);
    check("in_ready_done", int'(ir_v[i]), 0);
    $display("[TB] inst %0d beats %0d %0d %0d %0d -> acc %0d act %b", i, a, b, c, d,
             acc_of(i), act_v[i]);
    if (do_ack) begin
      ordy_v[i] = 1'b1;
      clk1();
      ordy_v[i] = 1'b0;
      check("valid_after_ack", int'(ov_v[i]), 0);
      check("ready_after_ack", int'(ir_v[i]), 1);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit c, input bit v, input int s,
                            input bit o);
    int lo, hi;
    lo = -(1 << (accw_of[i] - 1));
    hi = (1 << (accw_of[i] - 1)) - 1;
    if (r || c) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_pend[i] = 0; m_zero[i] = 1;
    end else if (m_pend[i]) begin
      if (o) m_pend[i] = 0;
    end else if (v) begin
      m_acc[i] = m_acc[i] + s;
      if (m_acc[i] > hi) m_acc[i] = hi;
      if (m_acc[i] < lo) m_acc[i] = lo;
      m_cnt[i]++;
      if (m_cnt[i] == beats_of[i]) begin
        m_res[i] = m_acc[i]; m_pend[i] = 1; m_zero[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1; clr_v[i] = 1'b0; iv_v[i] = 1'b0; ordy_v[i] = 1'b0; sum_v[i] = 4'd0;
      m_acc[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_pend[i] = 0; m_zero[i] = 1;
    end

    vecs[0] = '{0,  3,  2, -1,  4,   8, 2'b01};
    vecs[1] = '{0, -4, -4,  1,  0,  -7, 2'b11};
    vecs[2] = '{0,  1,  0,  0,  0,   1, 2'b00};
    vecs[3] = '{0, -1,  0,  0,  0,  -1, 2'b00};
    vecs[4] = '{0,  2,  0,  0,  0,   2, 2'b01};
    vecs[5] = '{0, -8, -8, -8, -8, -32, 2'b11};
    vecs[6] = '{1,  4,  4,  4,  4,   7, 2'b01};
    vecs[7] = '{1, -4, -4, -4, -4,  -8, 2'b11};
    vecs[8] = '{1,  4,  4, -4, -4,  -1, 2'b00};
    vecs[9] = '{1, -8, -8,  7,  0,  -1, 2'b00};

    clk1();
    clk1();
    for (int i = 0; i < 4; i++) begin
      check("rst_out_valid", int'(ov_v[i]), 0);
      check("rst_in_ready", int'(ir_v[i]), 1);
      check("rst_acc_out", acc_of(i), 0);
      check("rst_act_out", int'(act_v[i]), 0);
      rst_v[i] = 1'b0;
    end

    for (int v = 0; v < 10; v++) begin
      beats4(vecs[v].inst, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3,
             vecs[v].exp_acc, int'(vecs[v].exp_act), 1'b1);
    end

    // Backpressure: result held, input ignored, no bypass during the handshake cycle.
    beats4(0, 1, 1, 1, 1, 4, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      iv_v[0] = 1'b1; sum_v[0] = 4'd4; ordy_v[0] = 1'b0;
      clk1();
      check("bp_valid", int'(ov_v[0]), 1);
      check("bp_acc", acc_of(0), 4);
      check("bp_ready", int'(ir_v[0]), 0);
    end
    ordy_v[0] = 1'b1;
    clk1();
    ordy_v[0] = 1'b0;
    check("bp_ack_valid", int'(ov_v[0]), 0);
    check("bp_ack_ready", int'(ir_v[0]), 1);
    beats4(0, -1, -1, -1, -1, -4, 3, 1'b1);

    // Clear with in_valid drops the beat and the partial sum; clear in DONE drops the result.
    beat(0, 4);
    beat(0, 4);
    iv_v[0] = 1'b1; sum_v[0] = 4'd4; clr_v[0] = 1'b1;
    clk1();
    clr_v[0] = 1'b0; iv_v[0] = 1'b0;
    check("clr_valid", int'(ov_v[0]), 0);
    check("clr_ready", int'(ir_v[0]), 1);
    check("clr_acc", acc_of(0), 0);
    beats4(0, 1, 1, 1, 1, 4, 1, 1'b0);
    clr_v[0] = 1'b1;
    clk1();
    clr_v[0] = 1'b0;
    check("clr_done_valid", int'(ov_v[0]), 0);
    check("clr_done_acc", acc_of(0), 0);
    check("clr_done_act", int'(act_v[0]), 0);
    check("clr_done_ready", int'(ir_v[0]), 1);
    beats4(0, 2, 2, 2, 2, 8, 1, 1'b1);

    // Reset in the middle of an accumulation.
    beat(0, 3);
    beat(0, 3);
    iv_v[0] = 1'b0; rst_v[0] = 1'b1;
    clk1();
    rst_v[0] = 1'b0;
    check("mid_rst_valid", int'(ov_v[0]), 0);
    check("mid_rst_ready", int'(ir_v[0]), 1);
    check("mid_rst_acc", acc_of(0), 0);
    check("mid_rst_act", int'(act_v[0]), 0);
    beats4(0, 1, 1, 1, -3, 0, 0, 1'b1);

    // Random run on the BEATS=1 and BEATS=7 instances against the reference model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 2; i < 4; i++) begin
        bit r, c, v, o;
        int s;
        r = ($urandom_range(0, 79) == 0);
        c = ($urandom_range(0, 49) == 0);
        v = ($urandom_range(0, 2) != 0);
        o = ($urandom_range(0, 2) != 0);
        s = int'($urandom_range(0, 15)) - 8;
        rst_v[i] = r; clr_v[i] = c; iv_v[i] = v; ordy_v[i] = o; sum_v[i] = 4'(s);
        model_step(i, r, c, v, s, o);
      end
      clk1();
      for (int i = 2; i < 4; i++) begin
        check("rnd_valid", int'(ov_v[i]), int'(m_pend[i]));
        check("rnd_ready", int'(ir_v[i]), int'(!m_pend[i]));
        if (m_pend[i] || m_zero[i]) begin
          check("rnd_acc", acc_of(i), m_res[i]);
          check("rnd_act", int'(act_v[i]), act_ref(m_res[i], thr_of[i]));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
